// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: default width,
// FSM state encoding and the step-counter width helper.
package booth_pkg;

  localparam int WIDTH_DEF = 8;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Counter must hold 0..w, hence w+1 distinct values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/booth_if.sv
// Request/result bundle of the Booth multiplier: operands with a start
// strobe in one direction, the sticky valid flag and product in the other.
interface booth_if #(
  parameter int WIDTH = booth_pkg::WIDTH_DEF
);
  logic               start;
  logic [WIDTH-1:0]   X;
  logic [WIDTH-1:0]   Y;
  logic               valid;
  logic [2*WIDTH-1:0] Z;

  modport master (output start, X, Y, input valid, Z);
  modport slave  (input start, X, Y, output valid, Z);
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic right shift of {A,Q,q_1}.
module booth_step #(
  parameter int WIDTH = booth_pkg::WIDTH_DEF
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);
  logic [WIDTH:0] w_sum;

  always_comb begin
    // NOTE: default first so every path assigns w_sum and no latch is inferred.
    w_sum = i_a;
    case ({i_q[0], i_q_1})
      2'b10:   w_sum = i_a - i_m;
      2'b01:   w_sum = i_a + i_m;
      default: w_sum = i_a;
    endcase
  end

  assign {o_a, o_q, o_q_1} = {w_sum[WIDTH], w_sum, i_q};

endmodule

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier, one step per clock, WIDTH steps per
// product; result is registered and flagged with a sticky valid.
module booth_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic    clk,
  input logic    rst,
  booth_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t             r_state;
  logic [WIDTH:0]     r_a;
  logic [WIDTH:0]     r_m;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_1;
  logic [CW-1:0]      r_cnt;
  logic               r_valid;
  logic [2*WIDTH-1:0] r_z;

  logic [WIDTH:0]     w_a;
  logic [WIDTH-1:0]   w_q;
  logic               w_q_1;
  logic               w_last;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_a   (w_a),
    .o_q   (w_q),
    .o_q_1 (w_q_1)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are cleared too, so a reset leaves no stale operands behind.
      r_state <= S_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q_1   <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_z     <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a   <= w_a;
          r_q   <= w_q;
          r_q_1 <= w_q_1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_z     <= {w_a[WIDTH-1:0], w_q};
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; Z holds until overwritten.
          if (bus.start) begin
            r_m     <= {bus.X[WIDTH-1], bus.X};
            r_a     <= '0;
            r_q     <= bus.Y;
            r_q_1   <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_state <= S_RUN;
          end
        end
      endcase
    end
  end

  assign bus.valid = r_valid;
  assign bus.Z     = r_z;

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul: a latency/product model built on plain
// multiplication, checked every cycle, plus literal spot checks.
module tb_booth_mul;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic chk_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  booth_if #(.WIDTH(W)) bus ();

  booth_mul #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: accepted start when not busy; result appears W edges later.
  logic               m_busy  = 1'b0;
  int                 m_rem   = 0;
  logic signed [15:0] m_prod  = '0;
  logic               m_valid = 1'b0;
  logic [15:0]        m_z     = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_z     <= '0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy  <= 1'b1;
        m_rem   <= W;
        m_prod  <= $signed(bus.X) * $signed(bus.Y);
        m_valid <= 1'b0;
      end
    end else if (m_rem == 1) begin
      m_busy  <= 1'b0;
      m_z     <= m_prod;
      m_valid <= 1'b1;
    end else begin
      m_rem <= m_rem - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model valid", bus.valid, m_valid);
      check("model Z", bus.Z, m_z);
    end
  end

  task automatic do_mul(input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] ez, input string tag);
    int lat;
    @(negedge clk);
    bus.X = x; bus.Y = y; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.X = 8'($urandom); bus.Y = 8'($urandom);
    lat = 0;
    check({tag, " valid at load"}, bus.valid, 0);
    while (!bus.valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 8);
    check({tag, " Z"}, bus.Z, ez);
  endtask

  initial begin
    int lat;
    logic [7:0] x, y;
    logic signed [15:0] p;
    logic [15:0] z_hold;

    rst = 1'b1; bus.start = 1'b0; bus.X = '0; bus.Y = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset valid", bus.valid, 0);
    check("reset Z", bus.Z, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle valid", bus.valid, 0);
    end

    do_mul(8'd5, 8'd7, 16'd35, "5*7");
    z_hold = bus.Z;
    repeat (4) @(negedge clk);
    check("hold valid", bus.valid, 1);
    check("hold Z", bus.Z, z_hold);

    do_mul(8'hFC, 8'h06, 16'hFFE8, "-4*6");
    do_mul(8'h80, 8'h80, 16'h4000, "-128*-128");
    do_mul(8'h80, 8'h7F, 16'hC080, "-128*127");
    do_mul(8'h7F, 8'h7F, 16'h3F01, "127*127");
    do_mul(8'h00, 8'hB3, 16'h0000, "0*-77");

    // Start pulse and operand changes during RUN must be ignored.
    @(negedge clk);
    bus.X = 8'd3; bus.Y = 8'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        bus.start = 1'b1; bus.X = 8'd100; bus.Y = 8'hFF;
      end else if (lat == 4) begin
        bus.start = 1'b0; bus.X = 8'($urandom); bus.Y = 8'($urandom);
      end
    end
    check("midrun latency", lat, 8);
    check("midrun Z", bus.Z, 16'd27);

    // start held high: back-to-back restarts, each result valid one cycle.
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.X = 8'($urandom); bus.Y = 8'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the middle of a run.
    bus.X = 8'd50; bus.Y = 8'd50; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun reset valid", bus.valid, 0);
    check("midrun reset Z", bus.Z, 0);
    do_mul(8'd9, 8'hFD, 16'hFFE5, "post-reset 9*-3");

    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      p = $signed(x) * $signed(y);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_mul(x, y, p, "random");
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
